// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Single-port memory arbiter that shares one memory interface
//               between the instruction-fetch port and the load/store data
//               port. One transaction is outstanding at a time. Data requests
//               have priority, and a streak limit keeps fetch from starving.
//               Optional feature macro: MEM_ARB_TIMEOUT_EN (response timeout
//               with error return to the owning requester).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT_CYC  = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,

  // Instruction fetch port (read only)
  input  logic                i_req_i,
  input  logic [ADDR_W-1:0]   i_addr_i,
  output logic                i_gnt_o,
  output logic                i_rvalid_o,
  output logic [DATA_W-1:0]   i_rdata_o,
  output logic                i_err_o,

  // Load/store data port
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_err_o,

  // External memory port
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,

  output logic                busy_o
);

  // Streak counter must be able to hold MAX_D_STREAK itself.
  localparam int unsigned     c_STK_W   = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [c_STK_W-1:0] c_STK_MAX = c_STK_W'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [c_STK_W-1:0]    r_streak;
  logic                  r_owner_d;      // 1: data port owns the transaction

  logic                  r_mem_we;
  logic [DATA_W/8-1:0]   r_mem_be;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;

  logic                  r_i_rvalid;
  logic                  r_d_rvalid;
  logic [DATA_W-1:0]     r_i_rdata;
  logic [DATA_W-1:0]     r_d_rdata;

  logic                  w_idle;
  logic                  w_d_win;
  logic                  w_i_gnt;
  logic                  w_d_gnt;
  logic                  w_tmo_fire;
  logic                  w_resp_done;
  logic [DATA_W-1:0]     w_resp_data;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned        c_TMO_W    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'((TIMEOUT_CYC < 1) ? 0 : TIMEOUT_CYC - 1);

  logic [c_TMO_W-1:0]    r_tmo_cnt;
  logic                  r_i_err;
  logic                  r_d_err;

  // Timeout fires on the last allowed RESP cycle only if memory stays silent.
  assign w_tmo_fire = (r_state == ST_RESP) && !mem_rvalid_i && (r_tmo_cnt == c_TMO_LAST);

  // Count RESP cycles spent waiting for the memory response.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_tmo_cnt <= '0;
    end else if (r_state == ST_RESP && !mem_rvalid_i && !w_tmo_fire) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  // Error flag pulses alongside rvalid when the response timed out.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_i_err <= 1'b0;
      r_d_err <= 1'b0;
    end else begin
      r_i_err <= w_tmo_fire && !r_owner_d;
      r_d_err <= w_tmo_fire &&  r_owner_d;
    end
  end

  assign i_err_o = r_i_err;
  assign d_err_o = r_d_err;
`else
  // Timeout length has no effect without the timeout feature.
  localparam int unsigned c_unused_tmo = TIMEOUT_CYC;

  assign w_tmo_fire = 1'b0;
  assign i_err_o    = 1'b0;
  assign d_err_o    = 1'b0;
`endif

  // Arbitration: data wins unless fetch is waiting and the streak limit is hit.
  // Grants are suppressed while reset is asserted since nothing would latch.
  assign w_idle      = (r_state == ST_IDLE) && rst_i;
  assign w_d_win     = d_req_i && !(i_req_i && (r_streak == c_STK_MAX));
  assign w_d_gnt     = w_idle && w_d_win;
  assign w_i_gnt     = w_idle && i_req_i && !w_d_win;
  assign w_resp_done = (r_state == ST_RESP) && (mem_rvalid_i || w_tmo_fire);
  assign w_resp_data = mem_rvalid_i ? mem_rdata_i : '0;

  // Next-state logic for the single outstanding transaction.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_i_gnt || w_d_gnt) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_gnt_i) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (mem_rvalid_i || w_tmo_fire) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latch the winning payload and owner at grant time; held until next grant.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_owner_d   <= 1'b0;
    end else if (w_d_gnt) begin
      r_mem_we    <= d_we_i;
      r_mem_be    <= d_be_i;
      r_mem_addr  <= d_addr_i;
      r_mem_wdata <= d_wdata_i;
      r_owner_d   <= 1'b1;
    end else if (w_i_gnt) begin
      r_mem_we    <= 1'b0;
      r_mem_be    <= '1;
      r_mem_addr  <= i_addr_i;
      r_mem_wdata <= '0;
      r_owner_d   <= 1'b0;
    end
  end

  // Consecutive data grants while fetch waits; saturates at the limit.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_streak <= '0;
    end else if (w_i_gnt) begin
      r_streak <= '0;
    end else if (w_d_gnt) begin
      if (!i_req_i) begin
        r_streak <= '0;
      end else if (r_streak != c_STK_MAX) begin
        r_streak <= r_streak + 1'b1;
      end
    end
  end

  // Route the response to the owner as a one-cycle rvalid pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      if (w_resp_done) begin
        if (r_owner_d) begin
          r_d_rvalid <= 1'b1;
          r_d_rdata  <= w_resp_data;
        end else begin
          r_i_rvalid <= 1'b1;
          r_i_rdata  <= w_resp_data;
        end
      end
    end
  end

  assign i_gnt_o     = w_i_gnt;
  assign d_gnt_o     = w_d_gnt;
  assign i_rvalid_o  = r_i_rvalid;
  assign d_rvalid_o  = r_d_rvalid;
  assign i_rdata_o   = r_i_rdata;
  assign d_rdata_o   = r_d_rdata;

  assign mem_req_o   = (r_state == ST_REQ);
  assign mem_we_o    = r_mem_we;
  assign mem_be_o    = r_mem_be;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;

  assign busy_o      = (r_state != ST_IDLE);

endmodule

`default_nettype wire
